// File: rtl/key_event_buffer.sv
// Key event buffer: synchronises the decoder's one-hot key vector, debounces
// presses and releases, and queues one event per accepted press in a small
// show-ahead FIFO drained over a valid/ready handshake.
module key_event_buffer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] key_onehot,
  input  logic        key_ready,
  output logic        key_valid,
  output logic [4:0]  key_code,
  output logic        key_held,
  output logic        overflow
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntFW = PtrW + 1;
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntFW-1:0] FifoFull = CntFW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StCand, StPressed, StRelease} state_e;

  logic [31:0]      sync1_q, sync2_q;
  logic [4:0]       code_s;
  logic             ok_s;
  state_e           state_q, state_d;
  logic [4:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push;

  logic [4:0]       mem [FIFO_DEPTH];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntFW-1:0] count_q;
  logic             overflow_q;
  logic             pop, full, do_push;

  // Two-flop synchroniser; idle value is "no key" (bit 0 set)
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 32'h1;
      sync2_q <= 32'h1;
    end else begin
      sync1_q <= key_onehot;
      sync2_q <= sync1_q;
    end
  end

  // One-hot encoder; zero or multi-hot vectors collapse to code 0 (idle)
  always_comb begin
    logic [5:0] ones;
    logic [4:0] idx;
    ones = '0;
    idx  = '0;
    for (int i = 0; i < 32; i++) begin
      if (sync2_q[i]) begin
        ones = ones + 6'd1;
        idx  = 5'(i);
      end
    end
    ok_s   = (ones == 6'd1);
    code_s = ok_s ? idx : 5'd0;
  end

  // Debounce FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cand_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
    end
  end

  // Debounce FSM next state; push fires once per accepted press
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ok_s && code_s != 5'd0) begin
          cand_d  = code_s;
          cnt_d   = '0;
          state_d = StCand;
        end
      end
      StCand: begin
        if (code_s != cand_q) begin
          state_d = StIdle;
        end else if (cnt_q == CntLast) begin
          push    = 1'b1;
          state_d = StPressed;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StPressed: begin
        // Other keys while held are ignored; no auto-repeat
        if (code_s == 5'd0) begin
          cnt_d   = '0;
          state_d = StRelease;
        end
      end
      StRelease: begin
        if (code_s != 5'd0) begin
          state_d = StPressed;
        end else if (cnt_q == CntLast) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign key_valid = (count_q != '0);
  assign full      = (count_q == FifoFull);
  assign pop       = key_valid && key_ready;
  // A pop on the same edge frees the slot, so a full FIFO still accepts
  assign do_push   = push && (!full || pop);

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (pop)     rptr_q <= rptr_q + 1'b1;
      if (do_push && !pop)      count_q <= count_q + 1'b1;
      else if (!do_push && pop) count_q <= count_q - 1'b1;
      if (push && !do_push) overflow_q <= 1'b1;
    end
  end

  // FIFO storage; contents are masked by key_valid so no reset is needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= cand_q;
  end

  assign key_code = key_valid ? mem[rptr_q] : 5'd0;
  assign key_held = (state_q == StPressed) || (state_q == StRelease);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_key_event_buffer.sv
// Self-checking bench for key_event_buffer with a debounce of 4 cycles.
// Expected event codes are queued at stimulus time; a monitor pops and
// compares on every accepted handshake.
module tb_key_event_buffer;

  localparam int unsigned D = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] key_onehot;
  logic        key_ready;
  logic        key_valid;
  logic [4:0]  key_code;
  logic        key_held;
  logic        overflow;

  int vectors     = 0;
  int miscompares = 0;
  logic [4:0] exp_q[$];

  key_event_buffer #(
    .DEBOUNCE_CYCLES(D),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .key_onehot(key_onehot),
    .key_ready (key_ready),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int k, input int hold, input int gap);
    key_onehot = 32'h1 << k;
    tick(hold);
    key_onehot = 32'h1;
    tick(gap);
  endtask

  // Scoreboard monitor: every accepted event must match the queue head
  always @(negedge clk) begin
    if (!reset && key_valid && key_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_event: got code %0d expected none", key_code);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        check("event_code", {27'd0, key_code}, {27'd0, e});
      end
    end
  end

  initial begin
    reset      = 1'b1;
    key_onehot = 32'h1;
    key_ready  = 1'b0;
    tick(2);
    check("rst_valid", key_valid, 0);
    check("rst_code", key_code, 0);
    check("rst_held", key_held, 0);
    check("rst_ovf", overflow, 0);
    reset = 1'b0;

    // 1: idle vector produces nothing
    key_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("idle_quiet", {key_valid, key_held, key_code}, 0);
    end

    // 2: single press of key 5, edge 0 is the first sampling edge
    key_onehot = 32'h20;
    exp_q.push_back(5'd5);
    tick(1);
    tick(5);
    check("k5_early", key_valid, 0);
    tick(1);
    check("k5_valid", key_valid, 1);
    check("k5_code", key_code, 5);
    check("k5_held", key_held, 1);
    tick(1);
    check("k5_one_cycle", key_valid, 0);
    check("k5_held_on", key_held, 1);
    tick(4);
    key_onehot = 32'h1;
    tick(6);
    check("k5_held_rel", key_held, 1);
    tick(1);
    check("k5_released", key_held, 0);
    tick(10);
    check("k5_no_second", key_valid, 0);

    // 3: bounce on key 7, timing from second onset
    key_onehot = 32'h80;
    tick(3);
    key_onehot = 32'h1;
    tick(1);
    key_onehot = 32'h80;
    exp_q.push_back(5'd7);
    tick(1);
    tick(5);
    check("bounce_early", key_valid, 0);
    tick(1);
    check("bounce_valid", key_valid, 1);
    check("bounce_code", key_code, 7);
    tick(3);
    key_onehot = 32'h1;
    tick(12);
    check("bounce_rel", key_held, 0);

    // 4: fill FIFO with 1..4, key 5 overflows
    key_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      press(k, 8, 8);
      exp_q.push_back(5'(k));
    end
    check("full_no_ovf", overflow, 0);
    check("full_head", key_code, 1);
    press(5, 8, 8);
    check("ovf_set", overflow, 1);
    check("ovf_head", key_code, 1);
    key_ready = 1'b1;
    tick(4);
    check("drained", key_valid, 0);
    check("ovf_sticky", overflow, 1);

    // 5: multi-hot ignored; key 3 -> 9 switch restarts debounce
    key_onehot = 32'h6;
    tick(10);
    check("multihot_valid", key_valid, 0);
    check("multihot_held", key_held, 0);
    key_onehot = 32'h1;
    tick(3);
    key_onehot = 32'h8;
    tick(3);
    key_onehot = 32'h200;
    exp_q.push_back(5'd9);
    tick(1);
    tick(6);
    check("switch_early", key_valid, 0);
    tick(1);
    check("switch_valid", key_valid, 1);
    check("switch_code", key_code, 9);
    tick(2);
    key_onehot = 32'h1;
    tick(12);
    check("switch_rel", key_held, 0);

    // 6: reset mid-debounce with two queued entries
    key_ready = 1'b0;
    press(1, 8, 8);
    press(2, 8, 8);
    check("pre_rst_valid", key_valid, 1);
    key_onehot = 32'h40;
    tick(4);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    exp_q.delete();
    check("mid_rst_valid", key_valid, 0);
    check("mid_rst_code", key_code, 0);
    check("mid_rst_held", key_held, 0);
    check("mid_rst_ovf", overflow, 0);
    key_ready = 1'b1;
    exp_q.push_back(5'd6);
    tick(1);
    tick(5);
    check("redeb_early", key_valid, 0);
    tick(1);
    check("redeb_valid", key_valid, 1);
    check("redeb_code", key_code, 6);
    tick(3);
    key_onehot = 32'h1;
    tick(12);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/key_event_buffer.md
Name: key_event_buffer

Overview:
- Sits directly downstream of the 5-to-32 active-low key decoder in the calculator input path.
- Consumes its 32-bit one-hot key vector and synchronises it, then debounces presses and releases.
- Emits exactly one event per debounced key press and buffers the events in a small FIFO.
- The FIFO drains to the command/entry logic over a valid/ready handshake.
- One-hot bit 0 means "no key" (decoder input all-high); keys 1..31 are real keys.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles needed to accept a press or a release. Must be >= 1; benches use 4.
- FIFO_DEPTH, 4: event buffer depth. Power of two, >= 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES)+1: debounce counter width.

Ports:
- clk  input  1  system clock; everything on the rising edge.
- reset  input  1  synchronous, active-high reset.
- key_onehot  input  32  decoder output, asynchronous to clk; bit 0 = idle.
- key_ready  input  1  consumer accepts the head event this cycle.
- key_valid  output  1  FIFO non-empty.
- key_code  output  5  head event key index (1..31); 0 when empty.
- key_held  output  1  high in PRESSED and RELEASE states.
- overflow  output  1  sticky: an event was dropped because the FIFO was full.

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high (reset). The polarity and synchronicity are fixed.
- Reset, on the same edge: sync flops load 32'h1, FSM goes to IDLE, counter is 0, FIFO is emptied, key_valid=0, key_code=0, key_held=0, overflow=0. Reset mid-debounce or with a non-empty FIFO discards everything.
- Synchronizer: two flop stages on all 32 bits. The encoder on stage 2 produces code_s (5 bits) and ok_s.
  - ok_s=1 only when exactly one bit is set.
  - Zero or multi-hot input gives ok_s=0 and code_s=0, which is treated as idle.
- FSM states: IDLE, CAND, PRESSED, RELEASE.
  - IDLE: if ok_s and code_s!=0, then cand<=code_s, cnt<=0, go to CAND.
  - CAND: if code_s!=cand, go to IDLE (this covers release, a different key and an invalid vector).
  - CAND, code_s==cand, cnt==DEBOUNCE_CYCLES-1: push cand into the FIFO, go to PRESSED.
  - CAND, code_s==cand, otherwise: cnt<=cnt+1.
  - PRESSED: if code_s==0, then cnt<=0, go to RELEASE. Otherwise stay; other keys are ignored and there is no auto-repeat.
  - RELEASE: if code_s!=0, go to PRESSED.
  - RELEASE, code_s==0, cnt==DEBOUNCE_CYCLES-1: go to IDLE.
  - RELEASE, code_s==0, otherwise: cnt<=cnt+1.
- Latency: key_valid rises DEBOUNCE_CYCLES+2 rising edges after the first edge that samples the stable pressed key_onehot, when the FIFO was empty. With D=4 that is edge 6.
- FIFO:
  - Show-ahead: key_code is the head entry whenever key_valid=1.
  - Pop when key_valid && key_ready. key_ready while empty has no effect.
  - Push while full and not popping: the new event is dropped and overflow<=1. overflow stays 1 until reset.
  - Push and pop on the same edge while full: both happen, nothing is dropped, count is unchanged.
  - Push and pop on the same edge while holding 1 entry: key_code shows the pushed entry next cycle.
  - Read and write pointers wrap modulo FIFO_DEPTH. The count is held as a separate register of width $clog2(FIFO_DEPTH)+1.
- Events leave the FIFO in press order.

Test Plan:
1. Reset, then key_onehot=32'h1 for 20 cycles (D=4) -> key_valid=0, key_held=0, key_code=0 throughout.
2. key_onehot=32'h20 held 12 cycles, then 32'h1, key_ready=1:
   - key_valid=1 with key_code=5 for exactly one cycle, at edge 6 after the first sample.
   - key_held high from that edge until release debounce completes.
   - No second event.
3. Bounce: 32'h80 for 3 cycles, 32'h1 for 1 cycle, 32'h80 for 10 cycles (D=4) -> exactly one event with code 7, timed from the second press onset.
4. key_ready=0; press and release keys 1, 2, 3, 4, 5 in turn (each 8 cycles, idle 8 between, D=4):
   - overflow=1 after key 5 debounces.
   - Then key_ready=1 pops codes 1, 2, 3, 4 in order; key_valid falls after 4 pops.
5. Hold 32'h6 (multi-hot) for 10 cycles -> no event. In CAND on key 3, switch to key 9 -> counter restarts via IDLE; a single event with code 9 appears D+3 edges after the switch is sampled.
6. Assert reset for 1 cycle while in CAND with 2 entries in the FIFO -> next cycle key_valid=0, key_code=0, key_held=0, overflow=0. A held key is then re-debounced from scratch and produces one fresh event.
